encoder8x3_serial: RTL and testbench
====================================

ENCODER8X3_SERIAL -- requirements
Module: encoder8x3_serial

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1: in_vec is valid this cycle.
REQ-004 SHALL have port in_ready, output, 1: block can accept in_vec this cycle.
REQ-005 SHALL have port in_vec, input, 8: multi-hot line vector, bit k = line k active.
REQ-006 SHALL have port out_valid, output, 1: out_idx/out_last are valid.
REQ-007 SHALL have port out_ready, input, 1: consumer accepts the current index.
REQ-008 SHALL have port out_idx, output, 3: binary index of the emitted line.
REQ-009 SHALL have port out_last, output, 1: the current index is the final one for this vector.
REQ-010 SHALL have port remaining, output, 4: popcount of lines not yet emitted (0..8).
REQ-011 SHALL have port zero_err, output, 1: one-cycle pulse after an all-zero vector is accepted.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and EMIT, plus an 8-bit pending register.
REQ-013 In IDLE: in_ready=1, out_valid=0. In EMIT: in_ready=0, out_valid=1.
REQ-014 Input handshake: in_valid=1 and in_ready=1 at a rising edge SHALL accept in_vec.
REQ-015 On a nonzero accept: pending<=in_vec, state<=EMIT, out_valid=1 from the next cycle (1-cycle latency).
REQ-016 On an all-zero accept: state stays IDLE, pending is unchanged, zero_err=1 for exactly the next cycle.
REQ-017 zero_err SHALL be 0 in every other cycle.
REQ-018 In EMIT: out_idx = index of the highest set bit of pending; bit 7 has highest priority.
REQ-019 In EMIT: out_last=1 iff pending has exactly one bit set.
REQ-020 remaining SHALL equal popcount(pending) in EMIT and 0 in IDLE.
REQ-021 Output handshake: out_valid=1 and out_ready=1 at an edge SHALL clear pending[out_idx].
REQ-022 If out_last=1 at that handshake, the FSM SHALL return to IDLE and pending SHALL become 0.
REQ-023 Stall: while out_valid=1 and out_ready=0, out_idx, out_last, remaining and pending SHALL hold.
REQ-024 in_valid and in_vec SHALL be ignored in EMIT; no input is accepted while busy.
REQ-025 At least one IDLE cycle SHALL separate consecutive vectors.
REQ-026 out_ready SHALL be ignored in IDLE.
REQ-027 Throughput: an N-bit vector with out_ready held 1 SHALL emit N indices in N consecutive cycles.
REQ-028 out_idx and out_last SHALL be 0 whenever out_valid=0.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk: force state=IDLE, clear pending, and drive out_valid=0, out_idx=0, out_last=0, remaining=0, zero_err=0.
REQ-030 While rst_n=0, in_ready SHALL be 0; it SHALL be 1 in the first cycle after rst_n rises.
REQ-031 Reset asserted mid-EMIT SHALL discard pending indices; none SHALL be emitted after release.

Verification
REQ-032 Vector 8'b1010_0110, out_ready=1 -> out_idx 7,5,2,1 on consecutive cycles; out_last only with 1; remaining 4,3,2,1; then IDLE.
REQ-033 Vector 8'b0000_0001 -> single beat with out_idx=0, out_last=1, remaining=1; in_ready=1 on the following cycle.
REQ-034 Vector 8'h00 -> zero_err=1 for one cycle, out_valid stays 0, in_ready stays 1.
REQ-035 Vector 8'hFF with out_ready toggling 1,0,0,1,... -> outputs hold during stalls; idx 7..0 each emitted exactly once; total beats = 8.
REQ-036 Vector 8'hF0, rst_n pulsed low after the first beat -> outputs 0 immediately; after release in_ready=1 and no further beats.
REQ-037 in_valid=1 with a new vector during EMIT -> ignored; the first vector completes unchanged.

Source files
------------

// File: rtl/encoder8x3_serial.sv
// Serial 8-to-3 priority encoder: accepts a multi-hot line vector and emits the
// index of every set line, highest first, one per output handshake.
module encoder8x3_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_vec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_idx,
  output logic       out_last,
  output logic [3:0] remaining,
  output logic       zero_err
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state, state_nxt;
  logic [7:0] pending, pending_nxt;
  logic       zero_err_nxt;
  logic [2:0] top_idx;
  logic [7:0] top_mask;
  logic [3:0] cnt;
  logic       in_accept, out_fire;

  // Ascending scan: the last set bit seen wins, so bit 7 has top priority.
  always_comb begin
    top_idx = 3'd0;
    cnt     = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (pending[k]) top_idx = 3'(k);
      cnt = cnt + {3'd0, pending[k]};
    end
    top_mask = 8'd1 << top_idx;
  end

  // in_ready is gated by rst_n so it reads 0 throughout reset.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_idx   = out_valid ? top_idx : 3'd0;
  assign out_last  = out_valid && (cnt == 4'd1);
  assign remaining = out_valid ? cnt : 4'd0;

  assign in_accept = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    zero_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (in_accept) begin
          if (in_vec != 8'd0) begin
            pending_nxt = in_vec;
            state_nxt   = EMIT;
          end else begin
            zero_err_nxt = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          pending_nxt = pending & ~top_mask;
          if (out_last) begin
            pending_nxt = 8'd0;
            state_nxt   = IDLE;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pending  <= 8'd0;
      zero_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      zero_err <= zero_err_nxt;
    end
  end

endmodule

// File: tb/tb_encoder8x3_serial.sv
// Directed bench for encoder8x3_serial: table of vectors with hand-computed
// index sequences plus stall, reset-mid-emit and busy-input sequences.
module tb_encoder8x3_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic [3:0] remaining;
  logic       zero_err;

  int n_tests = 0;
  int n_fail  = 0;

  encoder8x3_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .remaining (remaining),
    .zero_err  (zero_err)
  );

  always #5 clk = ~clk;

  // seq holds beat b's index in nibble b (beat 0 in the lowest nibble).
  typedef struct {
    logic [7:0]  vec;
    int          nbeats;
    logic [31:0] seq;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic accept(input logic [7:0] v);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_vec   = v;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    int beats;
    logic [3:0] pat;

    tbl[0] = '{8'b1010_0110, 4, 32'h0000_1257};
    tbl[1] = '{8'h01,        1, 32'h0000_0000};
    tbl[2] = '{8'h00,        0, 32'h0000_0000};
    tbl[3] = '{8'h80,        1, 32'h0000_0007};
    tbl[4] = '{8'h18,        2, 32'h0000_0034};
    tbl[5] = '{8'h55,        4, 32'h0000_0246};

    rst_n = 1'b0; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;
    #3;
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_remaining", 32'(remaining), 32'd0);
    chk("rst_zero_err",  32'(zero_err),  32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Table-driven vectors with out_ready held high.
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      accept(tbl[t].vec);
      if (tbl[t].nbeats == 0) begin
        @(negedge clk);
        chk("zero_err_pulse",   32'(zero_err),  32'd1);
        chk("zero_out_valid",   32'(out_valid), 32'd0);
        chk("zero_in_ready",    32'(in_ready),  32'd1);
        @(negedge clk);
        chk("zero_err_cleared", 32'(zero_err),  32'd0);
      end else begin
        for (int b = 0; b < tbl[t].nbeats; b++) begin
          @(negedge clk);
          chk("beat_valid", 32'(out_valid), 32'd1);
          chk("beat_idx",   32'(out_idx),   32'(tbl[t].seq[4*b +: 3]));
          chk("beat_last",  32'(out_last),  32'(b == tbl[t].nbeats - 1));
          chk("beat_rem",   32'(remaining), 32'(tbl[t].nbeats - b));
          chk("beat_zerr",  32'(zero_err),  32'd0);
        end
        @(negedge clk);
        chk("done_out_valid", 32'(out_valid), 32'd0);
        chk("done_in_ready",  32'(in_ready),  32'd1);
        chk("done_idx_zero",  32'(out_idx),   32'd0);
        chk("done_last_zero", 32'(out_last),  32'd0);
        chk("done_rem_zero",  32'(remaining), 32'd0);
      end
    end

    // 8'hFF with out_ready pattern 1,0,0,1 repeating; stalls must hold outputs.
    pat = 4'b1001;
    beats = 0;
    out_ready = 1'b0;
    accept(8'hFF);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("ff_idx",  32'(out_idx),   32'(7 - beats));
        chk("ff_rem",  32'(remaining), 32'(8 - beats));
        chk("ff_last", 32'(out_last),  32'(beats == 7));
      end else begin
        break;
      end
      out_ready = pat[c % 4];
      if (out_ready) beats++;
    end
    chk("ff_total_beats", 32'(beats), 32'd8);
    chk("ff_idle", 32'(out_valid), 32'd0);

    // 8'hF0 with reset pulsed after the first beat.
    out_ready = 1'b1;
    accept(8'hF0);
    @(negedge clk);
    chk("f0_beat0_idx", 32'(out_idx), 32'd7);
    @(negedge clk);
    chk("f0_beat1_idx", 32'(out_idx), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("f0_rst_valid",    32'(out_valid), 32'd0);
    chk("f0_rst_idx",      32'(out_idx),   32'd0);
    chk("f0_rst_last",     32'(out_last),  32'd0);
    chk("f0_rst_rem",      32'(remaining), 32'd0);
    chk("f0_rst_in_ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("f0_release_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("f0_no_beats", 32'(out_valid), 32'd0);
    end

    // New vector offered while busy must be ignored.
    out_ready = 1'b1;
    accept(8'h18);
    @(negedge clk);
    chk("busy_idx0", 32'(out_idx),   32'd4);
    chk("busy_rem0", 32'(remaining), 32'd2);
    in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b0;
    @(negedge clk);
    chk("busy_hold_idx", 32'(out_idx),   32'd4);
    chk("busy_hold_rem", 32'(remaining), 32'd2);
    chk("busy_in_ready", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("busy_idx1",  32'(out_idx),   32'd3);
    chk("busy_rem1",  32'(remaining), 32'd1);
    chk("busy_last1", 32'(out_last),  32'd1);
    in_valid = 1'b0; in_vec = 8'h00;
    @(negedge clk);
    chk("busy_done_valid", 32'(out_valid), 32'd0);
    chk("busy_done_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    chk("busy_stays_idle", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
